// File: rtl/vp_issue_sequencer.sv
// vp_issue_sequencer: FIFO-buffered instruction issue with opcode-dependent occupancy and halt/resume.
// Optional VP_SEQ_BYPASS_EN lets an instruction skip the empty FIFO when the sequencer is idle.
module vp_issue_sequencer #(
    parameter int DEPTH   = 8,
    parameter int MEM_LAT = 4,
    parameter int ALU_LAT = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [12:0]              in_instr,
    output logic                     in_ready,
    input  logic                     resume,
    output logic [12:0]              issue_instr,
    output logic                     issue_valid,
    output logic                     busy,
    output logic                     retire,
    output logic                     halted,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int MAXL = MEM_LAT > ALU_LAT ? MEM_LAT : ALU_LAT;
    localparam int OW   = $clog2(MAXL + 1);

    typedef enum logic [1:0] {IDLE, BUSY, HALT} state_t;

    state_t          state, state_n;
    logic [12:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [OW-1:0]   occ, occ_n, lat_m1;
    logic            one_cyc;
    logic            empty, free, bypass, take, push, pop, is_halt;
    logic [12:0]     head;

    assign empty    = fifo_count == '0;
    assign in_ready = fifo_count != CW'(DEPTH);
    assign free     = state == IDLE || (state == BUSY && occ == '0);
`ifdef VP_SEQ_BYPASS_EN
    assign bypass   = state == IDLE && empty && in_valid;
`else
    assign bypass   = 1'b0;
`endif
    assign head     = bypass ? in_instr : mem[rd_ptr];
    assign take     = free && (!empty || bypass);
    assign is_halt  = head[12:11] == 2'b11;
    assign lat_m1   = head[12:11] == 2'b01 ? OW'(MEM_LAT - 1) :
                      head[12:11] == 2'b10 ? OW'(ALU_LAT - 1) : '0;
    assign push     = in_valid && in_ready && !bypass;
    assign pop      = take && !bypass;
    // Latency-1 instructions never enter BUSY, so one_cyc covers their single occupied cycle
    assign busy     = state == BUSY || one_cyc;
    assign retire   = (state == BUSY && occ == '0) || one_cyc;
    assign halted   = state == HALT;

    always_comb begin
        state_n = state;
        occ_n   = occ;
        if (state == HALT) begin
            state_n = resume ? IDLE : HALT;
        end else if (take) begin
            state_n = is_halt ? HALT : (lat_m1 != '0 ? BUSY : IDLE);
            occ_n   = lat_m1;
        end else if (state == BUSY) begin
            state_n = occ == '0 ? IDLE : BUSY;
            occ_n   = occ == '0 ? occ : occ - OW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            occ         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            issue_instr <= '0;
            issue_valid <= 1'b0;
            one_cyc     <= 1'b0;
        end else begin
            state       <= state_n;
            occ         <= occ_n;
            wr_ptr      <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr      <= pop ? rd_ptr + AW'(1) : rd_ptr;
            fifo_count  <= fifo_count + CW'(push) - CW'(pop);
            issue_valid <= take && !is_halt;
            one_cyc     <= take && !is_halt && lat_m1 == '0;
            if (take && !is_halt)
                issue_instr <= head;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_instr;
    end
endmodule

// File: tb/tb_vp_issue_sequencer.sv
// tb_vp_issue_sequencer: directed and random stimulus against a queue/timestamp reference model.
module tb_vp_issue_sequencer;
    localparam int DEPTH   = 8;
    localparam int MEM_LAT = 4;
    localparam int ALU_LAT = 2;

    logic        clk = 1'b0;
    logic        reset, in_valid, resume, in_ready;
    logic [12:0] in_instr, issue_instr;
    logic        issue_valid, busy, retire, halted;
    logic [3:0]  fifo_count;

    int errors = 0;
    int checks = 0;

    // reference model: queue of pending words, edge counter, edge at which the processor frees up
    int q[$];
    int cyc, free_e, m_instr;
    bit m_halt, last_multi, m_iv;

    vp_issue_sequencer #(.DEPTH(DEPTH), .MEM_LAT(MEM_LAT), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .resume(resume), .issue_instr(issue_instr),
        .issue_valid(issue_valid), .busy(busy), .retire(retire),
        .halted(halted), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int lat_of(input int w);
        int c;
        c = (w >> 11) & 3;
        return c == 1 ? MEM_LAT : c == 2 ? ALU_LAT : 1;
    endfunction

    task automatic model_reset();
        q.delete();
        cyc = 0;
        free_e = 0;
        m_halt = 0;
        last_multi = 0;
        m_iv = 0;
        m_instr = 0;
    endtask

    task automatic model_edge();
        bit push_ok, popped, idle;
        int w;
        cyc++;
        if (reset) begin
            model_reset();
            return;
        end
        m_iv = 0;
        popped = 0;
        w = 0;
        push_ok = in_valid && q.size() < DEPTH;
        idle = !m_halt && (cyc > free_e || (cyc == free_e && !last_multi));
        if (m_halt) begin
            if (resume) m_halt = 0;
        end else if (cyc >= free_e && q.size() > 0) begin
            w = q.pop_front();
            popped = 1;
        end
`ifdef VP_SEQ_BYPASS_EN
        else if (idle && in_valid) begin
            w = int'(in_instr);
            popped = 1;
            push_ok = 0;
        end
`endif
        if (popped) begin
            if (((w >> 11) & 3) == 3) begin
                m_halt = 1;
            end else begin
                m_iv = 1;
                m_instr = w;
                free_e = cyc + lat_of(w);
                last_multi = lat_of(w) > 1;
            end
        end
        if (push_ok) q.push_back(int'(in_instr));
        if (idle) ;
    endtask

    task automatic check_all();
        check("issue_valid", int'(issue_valid), int'(m_iv));
        check("issue_instr", int'(issue_instr), m_instr);
        check("busy", int'(busy), int'(cyc < free_e));
        check("retire", int'(retire), int'(cyc == free_e - 1));
        check("halted", int'(halted), int'(m_halt));
        check("fifo_count", int'(fifo_count), q.size());
        check("in_ready", int'(in_ready), int'(q.size() != DEPTH));
    endtask

    task automatic cycle(input bit v, input logic [12:0] w, input bit r);
        in_valid = v;
        in_instr = w;
        resume = r;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        in_valid = 0;
        resume = 0;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cycle(0, 13'h0, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_issue_instr"}, int'(issue_instr), 0);
        check({tag, "_issue_valid"}, int'(issue_valid), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_retire"}, int'(retire), 0);
        check({tag, "_halted"}, int'(halted), 0);
        check({tag, "_fifo_count"}, int'(fifo_count), 0);
        check({tag, "_in_ready"}, int'(in_ready), 1);
    endtask

    initial begin
        reset = 1;
        in_valid = 0;
        in_instr = 0;
        resume = 0;
        model_reset();
        #1;
        check_reset_values("por");
        cycle(0, 13'h0, 0);
        cycle(0, 13'h0, 0);
        reset = 0;

        cycle(1, 13'h0C00, 0);
        idle_n(7);

        for (int i = 0; i < 3; i++) cycle(1, 13'h0000, 0);
        idle_n(4);

        cycle(1, 13'h0C00, 0);
        cycle(1, 13'h1000, 0);
        idle_n(10);

        cycle(1, 13'h1800, 0);
        idle_n(2);
        for (int i = 0; i < 9; i++) cycle(1, 13'((i % 2 == 1 ? 'h1000 : 'h0000) | (i + 1)), 0);
        check("full_count", int'(fifo_count), DEPTH);
        check("full_ready", int'(in_ready), 0);
        cycle(0, 13'h0, 1);
        idle_n(30);

        cycle(0, 13'h0, 1);
        cycle(1, 13'h1000, 1);
        cycle(0, 13'h0, 1);
        idle_n(4);
        cycle(1, 13'h1800, 0);
        cycle(1, 13'h0C00, 0);
        idle_n(3);
        cycle(0, 13'h0, 1);
        idle_n(8);

        cycle(1, 13'h1000, 0);
        cycle(1, 13'h0C00, 0);
        cycle(1, 13'h0001, 0);
        cycle(1, 13'h0002, 0);
        cycle(1, 13'h0003, 0);
        reset = 1;
        #1;
        check_reset_values("mid");
        model_reset();
        cycle(0, 13'h0, 0);
        reset = 0;
        idle_n(10);

        for (int i = 0; i < 600; i++) begin
            int r, c;
            r = int'($urandom % 8);
            c = r < 3 ? 0 : r < 5 ? 1 : r < 7 ? 2 : 3;
            cycle(bit'($urandom % 2), {2'(c), 11'($urandom)}, bit'($urandom % 6 == 0));
        end
        idle_n(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vp_issue_sequencer.md
# vp_issue_sequencer

Instruction issue controller sitting in front of `vector_processor`. It buffers 13-bit instructions from a host or loader in a small FIFO. It issues them one at a time on the processor's `instruction_set` input, holding off further issue for an opcode-dependent occupancy so that multi-cycle 512-bit memory and arithmetic operations complete before the next instruction arrives. It also implements a halt/resume control instruction.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `MEM_LAT`, 4: occupancy in cycles of a memory-class instruction; ≥1.
- `ALU_LAT`, 2: occupancy in cycles of an arithmetic-class instruction; ≥1.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `in_valid` in 1: host offers `in_instr`.
- `in_instr` in 13: instruction word.
- `in_ready` out 1: FIFO can accept; transfer on `in_valid & in_ready` at a rising edge.
- `resume` in 1: single-cycle pulse leaving the HALT state.
- `issue_instr` out 13: drives `vector_processor.instruction_set`.
- `issue_valid` out 1: high for exactly one cycle per issued instruction.
- `busy` out 1: the processor is occupied by an issued instruction.
- `retire` out 1: one-cycle pulse in the last occupied cycle.
- `halted` out 1: the sequencer is in HALT.
- `fifo_count` out $clog2(DEPTH)+1: entries held.

## Operation
- Opcode class is `instr[12:11]`. 00 is NOP with occupancy 1. 01 is memory with occupancy MEM_LAT. 10 is arithmetic with occupancy ALU_LAT. 11 is HALT, which is never issued. `instr[10:0]` passes through untouched.
- FIFO: circular, read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
  - `in_ready = (fifo_count != DEPTH)`. It is registered-state only, with no combinational path from `in_valid`.
  - A simultaneous push and pop leaves the count unchanged. When full, a push and pop in the same cycle is impossible because `in_ready` is 0.
- FSM states are IDLE, BUSY and HALT.
  - **IDLE**, FIFO non-empty:
    - Pop the head entry.
    - If it is not HALT: register it into `issue_instr` and assert `issue_valid` for the next cycle. Load the occupancy counter `occ` with latency−1. Go to BUSY if latency>1, otherwise stay in IDLE.
    - If it is HALT: go to HALT. No issue, no retire.
  - **BUSY**: `occ` decrements each cycle. At `occ==0` go to IDLE and, in that same cycle, pop and issue the next entry if one is present.
  - **HALT**: `halted=1` and no pops. A `resume` pulse moves to IDLE at the next edge. Pushes continue while halted.
- `resume` outside HALT is ignored.
- `issue_instr` holds its last issued value between issues.
- Reset values:
  - `issue_instr=0`, `issue_valid=0`, `busy=0`, `retire=0`, `halted=0`.
  - `fifo_count=0`, `in_ready=1`, state IDLE, pointers 0.
- Reset mid-operation drops both the in-flight instruction and the FIFO contents. No `retire` is generated for the dropped instruction.

## Timing
- Pop at edge E:
  - `issue_valid` is high in cycle E+1 only.
  - `busy` is high for cycles E+1 … E+lat.
  - `retire` is high in cycle E+lat.
- The next `issue_valid` occurs at the earliest in cycle E+lat+1. Latency-1 instructions issue every cycle with no gap.
- Push-to-issue latency when IDLE and the FIFO is empty is 2 cycles. The push at E0 writes the FIFO; the pop at E1 gives `issue_valid` in cycle E1+1.
- `fifo_count` updates on the edge after a push or pop.
- HALT popped at E: `halted=1` from E+1. A `resume` sampled at edge R gives `halted=0` from R+1, and the first post-resume `issue_valid` is at R+2 at the earliest.

## Configuration
- `VP_SEQ_BYPASS_EN`: when defined, an instruction accepted at E0 bypasses the FIFO if the state is IDLE and the FIFO is empty. It goes directly into `issue_instr` with `issue_valid` in cycle E0+1, the FIFO is not written and `fifo_count` stays 0.
  - The bypass applies to HALT too: it enters HALT at E0+1.
- Without the macro, all instructions pass through the FIFO with the 2-cycle minimum latency.

## Test plan
- Reset then push `13'h0C00` (store A3 to 0x00) with defaults:
  - `issue_instr=0x0C00` with `issue_valid` in cycle push+2 (push+1 with bypass).
  - `busy` high for 4 cycles, `retire` in the 4th.
- Push NOP `0x0000` ×3 back-to-back: three consecutive `issue_valid` pulses with no gaps.
- Push `0x0C00` then `0x1000`: the second `issue_valid` arrives exactly 4 cycles after the first, and `busy` spans 4+2 contiguous cycles.
- Fill 8 entries while the sequencer is halted: `in_ready=0` and `fifo_count=8`; a 9th offer is not accepted. After `resume`, entries drain in order across the pointer wrap.
- Push `0x1800` then `0x0C00`:
  - `halted=1` with no issue.
  - `0x0C00` is held until `resume`, then issued 2 cycles after the resume edge.
  - `resume` pulses while not halted have no effect.
- Assert `reset` in the 2nd cycle of a MEM_LAT occupancy with 3 entries queued:
  - All outputs go to reset values immediately and `fifo_count=0`.
  - No `retire` follows, and no stale issue occurs after release.
